// File: rtl/gemm_pkg.sv
// Shared defaults and types for the GEMM output-side controller.
package gemm_pkg;
   localparam int DEF_N_OUT = 8;
   localparam int DEF_N_BLK = 4;
   localparam int DEF_DW    = 32;
   localparam int DEF_AW    = 4;

   typedef enum logic [1:0] {IDLE, RD, FLUSH} out_st_t;
endpackage

// File: rtl/out_skid.sv
// Two-entry FIFO feeding the stream master; head entry drives the stream outputs.
module out_skid
   import gemm_pkg::*;
#(
   parameter int W = DEF_DW + 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic [1:0]   free_cnt
);

   logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;

   // Pop shifts the tail forward first, so a simultaneous push lands behind it.
   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      if (pop && (cnt_q != 2'd0)) begin
         e0_d  = e1_q;
         cnt_d = cnt_q - 2'd1;
      end
      if (push && (cnt_d != 2'd2)) begin
         if (cnt_d == 2'd0) e0_d = din;
         else               e1_d = din;
         cnt_d = cnt_d + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= 2'd0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign dout     = e0_q;
   assign empty    = (cnt_q == 2'd0);
   assign free_cnt = 2'd2 - cnt_q;

endmodule

// File: rtl/out_ctl.sv
// Output controller: tracks the 2-bank result buffer and drains filled banks
// in address order onto an AXI-Stream master through a 2-entry skid FIFO.
module out_ctl
   import gemm_pkg::*;
#(
   parameter int N_OUT = DEF_N_OUT,
   parameter int N_BLK = DEF_N_BLK,
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_init,
   input  logic          k_fin,
   output logic          wbank,
   output logic          out_busy,
   output logic          outr,
   output logic          rd_en,
   output logic [AW-1:0] ra,
   input  logic [DW-1:0] rd_data,
   output logic [DW-1:0] m_tdata,
   output logic          m_tvalid,
   input  logic          m_tready,
   output logic          m_tlast,
   output logic          ovf_err
);

   localparam int OCW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int BKW = (N_BLK > 1) ? $clog2(N_BLK) : 1;
   localparam logic [OCW-1:0] OC_LAST  = OCW'(N_OUT - 1);
   localparam logic [BKW-1:0] BLK_LAST = BKW'(N_BLK - 1);

   out_st_t        st_q, st_d;
   logic [1:0]     cnt_q, cnt_d;
   logic           wbank_q, wbank_d, rbank_q, rbank_d;
   logic [OCW-1:0] oc_q, oc_d;
   logic [BKW-1:0] blk_q, blk_d;
   logic           busy_q, busy_d, ovf_q, ovf_d;
   logic           infl_q, infl_d, tag_q, tag_d;

   logic           pop, empty, drain, kfin_ok;
   logic [1:0]     free_cnt;
   logic [2:0]     room;
   logic [DW:0]    head;

   // A read may issue only if the word already in flight and this one both
   // fit once this cycle's pop has been taken into account.
   always_comb begin
      pop     = m_tvalid & m_tready;
      room    = {1'b0, free_cnt} + {2'b0, pop};
      rd_en   = (st_q == RD) && (room >= ({2'b0, infl_q} + 3'd1));
      drain   = rd_en && (oc_q == OC_LAST);
      kfin_ok = k_fin && !((cnt_q == 2'd2) && !drain);

      cnt_d = cnt_q;
      case ({kfin_ok, drain})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase

      wbank_d = wbank_q ^ kfin_ok;
      rbank_d = rbank_q ^ drain;
      ovf_d   = ovf_q | (k_fin & ~kfin_ok);
      busy_d  = (cnt_d == 2'd2);
      infl_d  = rd_en;
      tag_d   = drain && (blk_q == BLK_LAST);

      oc_d = oc_q;
      if (drain)      oc_d = '0;
      else if (rd_en) oc_d = oc_q + OCW'(1);

      blk_d = blk_q;
      if (s_init)     blk_d = '0;
      else if (drain) blk_d = (blk_q == BLK_LAST) ? '0 : blk_q + BKW'(1);

      st_d = st_q;
      case (st_q)
         IDLE:    if (cnt_d != 2'd0) st_d = RD;
         RD:      if (drain) st_d = FLUSH;
         FLUSH:   if (infl_q) st_d = (cnt_d != 2'd0) ? RD : IDLE;
         default: st_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         st_q    <= IDLE;
         cnt_q   <= 2'd0;
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         oc_q    <= '0;
         blk_q   <= '0;
         busy_q  <= 1'b0;
         ovf_q   <= 1'b0;
         infl_q  <= 1'b0;
         tag_q   <= 1'b0;
      end else begin
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         oc_q    <= oc_d;
         blk_q   <= blk_d;
         busy_q  <= busy_d;
         ovf_q   <= ovf_d;
         infl_q  <= infl_d;
         tag_q   <= tag_d;
      end
   end

   out_skid #(.W(DW + 1)) u_skid (
      .clk      (clk),
      .rst      (rst),
      .push     (infl_q),
      .din      ({tag_q, rd_data}),
      .pop      (pop),
      .dout     (head),
      .empty    (empty),
      .free_cnt (free_cnt)
   );

   always_comb begin
      ra = AW'(oc_q);
      if (rbank_q) ra = ra + AW'(N_OUT);
   end

   assign m_tvalid = ~empty;
   assign m_tdata  = head[DW-1:0];
   assign m_tlast  = head[DW];
   assign wbank    = wbank_q;
   assign out_busy = busy_q;
   assign ovf_err  = ovf_q;
   assign outr     = (st_q != IDLE) | (cnt_q != 2'd0) | infl_q | ~empty;

endmodule

// File: tb/tb_out_ctl.sv
// Self-checking bench for out_ctl: cycle table, directed corner sequences and
// randomized back-pressure against a queue-based stream model.
module tb_out_ctl;
   localparam int N_OUT = 8;
   localparam int N_BLK = 4;
   localparam int DW    = 32;
   localparam int AW    = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, s_init, k_fin, m_tready;
   logic          wbank, out_busy, outr, rd_en, m_tvalid, m_tlast, ovf_err;
   logic [AW-1:0] ra;
   logic [DW-1:0] m_tdata;
   logic [DW-1:0] rd_data = '0;

   out_ctl #(.N_OUT(N_OUT), .N_BLK(N_BLK), .DW(DW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .s_init(s_init), .k_fin(k_fin), .wbank(wbank),
      .out_busy(out_busy), .outr(outr), .rd_en(rd_en), .ra(ra), .rd_data(rd_data),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
      .ovf_err(ovf_err)
   );

   // Result-buffer RAM: one cycle read latency.
   logic [DW-1:0] mem [0:2*N_OUT-1];
   always @(posedge clk) if (rd_en) rd_data <= mem[ra];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
      end
   endtask

   // Stream model: every accepted block appends its words, in order, to exp_q.
   logic [DW:0]   exp_q[$];
   logic [DW:0]   e_word, prev_head;
   logic [DW-1:0] pend [N_OUT];
   int            pend_bank;
   int            beats;
   int            blk_m;
   bit            wb_m, mon_en, prev_stall;

   always @(negedge clk) begin
      if (mon_en) begin
         if (prev_stall) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_data", {m_tlast, m_tdata}, prev_head);
         end
         if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: actual %0h required none at %0t", {m_tlast, m_tdata}, $time);
            end else begin
               e_word = exp_q.pop_front();
               chk("beat", {m_tlast, m_tdata}, e_word);
            end
            beats++;
         end
         prev_stall = m_tvalid && !m_tready;
         prev_head  = {m_tlast, m_tdata};
      end else begin
         prev_stall = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic gen_block();
      for (int w = 0; w < N_OUT; w++) begin
         pend[w] = $urandom;
         exp_q.push_back({(w == N_OUT - 1) && (blk_m == N_BLK - 1), pend[w]});
      end
      pend_bank = int'(wb_m);
      wb_m      = !wb_m;
      blk_m     = (blk_m + 1) % N_BLK;
   endtask

   task automatic write_pend();
      for (int w = 0; w < N_OUT; w++) mem[pend_bank*N_OUT + w] = pend[w];
   endtask

   task automatic kfin_pulse();
      gen_block();
      write_pend();
      k_fin = 1'b1;
      step();
      k_fin = 1'b0;
   endtask

   task automatic sinit_pulse();
      s_init = 1'b1;
      step();
      s_init = 1'b0;
      blk_m  = 0;
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b0; k_fin = 1'b0; s_init = 1'b0; m_tready = 1'b0;
      exp_q.delete();
      wb_m = 1'b0; blk_m = 0; beats = 0;
      repeat (2) step();
      rst = 1'b1;
      step();
      mon_en = 1'b1;
   endtask

   task automatic wait_drain(input int budget, input string nm);
      int n = 0;
      while ((outr || exp_q.size() != 0) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s: actual timeout (%0d words left) required drained at %0t", nm, exp_q.size(), $time);
      end
   endtask

   typedef struct {
      logic          kf;
      logic          rde;
      logic [AW-1:0] ra_e;
      logic          tv;
      logic [DW-1:0] td;
      logic          ou;
      logic          wb;
   } vec_t;
   vec_t tbl [12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1);
   end

   initial begin
      int  sent;
      bit  hit, seen, done;

      // Single block, ready held high: cycle 0 carries k_fin.
      tbl[0]  = '{1'b1, 1'b0, 4'd0, 1'b0, 32'h0,         1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b1, 4'd0, 1'b0, 32'h0,         1'b1, 1'b1};
      tbl[2]  = '{1'b0, 1'b1, 4'd1, 1'b0, 32'h0,         1'b1, 1'b1};
      tbl[3]  = '{1'b0, 1'b1, 4'd2, 1'b1, 32'hA000_0000, 1'b1, 1'b1};
      tbl[4]  = '{1'b0, 1'b1, 4'd3, 1'b1, 32'hA000_0001, 1'b1, 1'b1};
      tbl[5]  = '{1'b0, 1'b1, 4'd4, 1'b1, 32'hA000_0002, 1'b1, 1'b1};
      tbl[6]  = '{1'b0, 1'b1, 4'd5, 1'b1, 32'hA000_0003, 1'b1, 1'b1};
      tbl[7]  = '{1'b0, 1'b1, 4'd6, 1'b1, 32'hA000_0004, 1'b1, 1'b1};
      tbl[8]  = '{1'b0, 1'b1, 4'd7, 1'b1, 32'hA000_0005, 1'b1, 1'b1};
      tbl[9]  = '{1'b0, 1'b0, 4'd8, 1'b1, 32'hA000_0006, 1'b1, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 4'd8, 1'b1, 32'hA000_0007, 1'b1, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 4'd8, 1'b0, 32'h0,         1'b0, 1'b1};

      do_reset();
      mon_en = 1'b0;
      @(negedge clk);
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_outr", outr, 0);
      chk("rst_wbank", wbank, 0);
      chk("rst_ra", ra, 0);
      chk("rst_busy", out_busy, 0);
      chk("rst_ovf", ovf_err, 0);
      step();
      for (int w = 0; w < 2*N_OUT; w++) mem[w] = 32'hA000_0000 + w;
      m_tready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         k_fin = tbl[i].kf;
         @(negedge clk);
         chk("t1_rd_en", rd_en, tbl[i].rde);
         chk("t1_ra", ra, tbl[i].ra_e);
         chk("t1_tvalid", m_tvalid, tbl[i].tv);
         if (tbl[i].tv) chk("t1_tdata", m_tdata, tbl[i].td);
         chk("t1_tlast", m_tlast, 0);
         chk("t1_outr", outr, tbl[i].ou);
         chk("t1_wbank", wbank, tbl[i].wb);
         chk("t1_busy", out_busy, 0);
         step();
      end
      k_fin = 1'b0;

      // Full set of four blocks, tlast only on the final word.
      do_reset();
      m_tready = 1'b1;
      sinit_pulse();
      for (int b = 0; b < N_BLK; b++) begin
         kfin_pulse();
         repeat (9) step();
      end
      wait_drain(200, "t2_drain");
      chk("t2_beats", beats, 4*N_OUT);

      // Both banks filled under back-pressure.
      do_reset();
      m_tready = 1'b0;
      kfin_pulse();
      kfin_pulse();
      chk("t3_busy_rise", out_busy, 1);
      repeat (4) step();
      @(negedge clk);
      chk("t3_rd_stalled", rd_en, 0);
      chk("t3_tvalid", m_tvalid, 1);
      chk("t3_busy_held", out_busy, 1);
      step();
      m_tready = 1'b1;
      seen = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (seen) begin
            chk("t3_busy_fall", out_busy, 0);
            done = 1'b1;
         end else if (rd_en && ra == AW'(N_OUT - 1)) begin
            chk("t3_busy_before_fall", out_busy, 1);
            seen = 1'b1;
         end
         step();
      end
      chk("t3_w7_read_seen", done, 1);
      wait_drain(200, "t3_drain");
      chk("t3_beats", beats, 2*N_OUT);

      // Random back-pressure over two full sets.
      do_reset();
      for (int s = 0; s < 2; s++) begin
         beats = 0;
         sinit_pulse();
         sent = 0;
         for (int c = 0; c < 3000 && (sent < N_BLK || outr || exp_q.size() != 0); c++) begin
            m_tready = 1'($urandom_range(0, 1));
            k_fin    = 1'b0;
            if (sent < N_BLK && !out_busy && $urandom_range(0, 3) == 0) begin
               gen_block();
               write_pend();
               k_fin = 1'b1;
               sent++;
            end
            step();
         end
         k_fin    = 1'b0;
         m_tready = 1'b1;
         wait_drain(100, "t4_drain");
         chk("t4_beats", beats, N_BLK*N_OUT);
      end

      // k_fin with both banks full is dropped and flagged.
      do_reset();
      m_tready = 1'b0;
      kfin_pulse();
      kfin_pulse();
      repeat (2) step();
      k_fin = 1'b1;
      step();
      k_fin = 1'b0;
      @(negedge clk);
      chk("t5_ovf_set", ovf_err, 1);
      chk("t5_wbank_hold", wbank, wb_m);
      chk("t5_busy", out_busy, 1);
      step();
      m_tready = 1'b1;
      wait_drain(200, "t5a_drain");
      chk("t5a_beats", beats, 2*N_OUT);
      chk("t5a_ovf_sticky", ovf_err, 1);

      // k_fin coinciding with the read of a bank's last word is accepted.
      do_reset();
      m_tready = 1'b0;
      kfin_pulse();
      kfin_pulse();
      repeat (3) step();
      m_tready = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 40 && !hit; c++) begin
         #1;
         if (rd_en && ra == AW'(N_OUT - 1)) begin
            hit = 1'b1;
            gen_block();
            k_fin = 1'b1;
            step();
            k_fin = 1'b0;
            write_pend();
         end else begin
            step();
         end
      end
      chk("t5b_coincide_seen", hit, 1);
      @(negedge clk);
      chk("t5b_no_ovf", ovf_err, 0);
      chk("t5b_busy", out_busy, 1);
      chk("t5b_wbank", wbank, wb_m);
      step();
      wait_drain(300, "t5b_drain");
      chk("t5b_beats", beats, 3*N_OUT);

      // Reset asserted mid-drain.
      do_reset();
      m_tready = 1'b1;
      kfin_pulse();
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         if (rd_en && ra == AW'(4)) hit = 1'b1;
         else step();
      end
      chk("t6_oc4_seen", hit, 1);
      mon_en = 1'b0;
      rst    = 1'b0;
      #1;
      chk("t6_rd_en", rd_en, 0);
      chk("t6_ra", ra, 0);
      chk("t6_tvalid", m_tvalid, 0);
      chk("t6_tdata", m_tdata, 0);
      chk("t6_tlast", m_tlast, 0);
      chk("t6_wbank", wbank, 0);
      chk("t6_busy", out_busy, 0);
      chk("t6_outr", outr, 0);
      chk("t6_ovf", ovf_err, 0);
      do_reset();
      m_tready = 1'b1;
      kfin_pulse();
      wait_drain(100, "t6_drain");
      chk("t6_beats", beats, N_OUT);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
